// File: rtl/mc_ctrl_pkg.sv
// Shared constants, state encoding and control bundle
// for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;
  localparam logic [1:0] AOP_SLT = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_OUT = 2'b10;
  localparam logic [1:0] PC_A   = 2'b11;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_BRANCH,
    S_I_EXEC, S_I_WB, S_JUMP, S_JAL, S_JR
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_en;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       is_bne;
    logic       jmp;
    logic       jr;
  } ctrl_t;

  function automatic logic is_rfn(input logic [5:0] fn);
    return (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) ||
           (fn == F_OR)  || (fn == F_SLT);
  endfunction

  // Opcode is only consulted for states entered from DECODE or later.
  function automatic ctrl_t dec_ctrl(input state_e s,
                                     input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_en    = 1'b1;
        c.alu_op    = AOP_ADD;
        c.pc_src    = PC_ALU;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BR;
        c.alu_en    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_en    = 1'b1;
      end
      S_MEM_READ: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_dst    = RD_RT;
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_en    = 1'b1;
        c.alu_op    = AOP_FN;
      end
      S_R_WB: begin
        c.reg_dst   = RD_RD;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_en        = 1'b1;
        c.alu_op        = AOP_SUB;
        c.pc_src        = PC_OUT;
        c.pc_write_cond = 1'b1;
        c.is_bne        = (op == OP_BNE);
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_en    = 1'b1;
        c.alu_op    = (op == OP_SLTI) ? AOP_SLT : AOP_ADD;
      end
      S_I_WB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = PC_JMP;
        c.pc_write = 1'b1;
        c.jmp      = 1'b1;
      end
      S_JAL: begin
        c.pc_src     = PC_JMP;
        c.pc_write   = 1'b1;
        c.jmp        = 1'b1;
        c.reg_dst    = RD_RA;
        c.mem_to_reg = M2R_PC;
        c.reg_write  = 1'b1;
      end
      S_JR: begin
        c.pc_src   = PC_A;
        c.pc_write = 1'b1;
        c.jr       = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero in,
// every datapath select/enable and the fetch counter out.
interface mc_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             IorD;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       pc_src;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_en;
  logic             jmp;
  logic             jr;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output IorD, mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_ctrl,
    output pc_src, pc_write, pc_write_cond, pc_en,
    output jmp, jr, illegal_op, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  IorD, mem_read, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_ctrl,
    input  pc_src, pc_write, pc_write_cond, pc_en,
    input  jmp, jr, illegal_op, instr_count
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's alu_op class plus R-type funct
// onto the 3-bit ALU operation select.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      AOP_ADD: o_alu_ctrl = ALU_ADD;
      AOP_SUB: o_alu_ctrl = ALU_SUB;
      AOP_SLT: o_alu_ctrl = ALU_SLT;
      default: begin
        case (i_funct)
          F_SUB:   o_alu_ctrl = ALU_SUB;
          F_AND:   o_alu_ctrl = ALU_AND;
          F_OR:    o_alu_ctrl = ALU_OR;
          F_SLT:   o_alu_ctrl = ALU_SLT;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: registered Moore controls,
// Mealy pc_en on zero, DECODE-time illegal_op pulse.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mc_controller_if.master bus
);

  state_e           r_state;
  state_e           w_nxt;
  ctrl_t            r_ctl;
  logic [CNT_W-1:0] r_cnt;
  logic             w_illegal;
  logic [2:0]       w_alu;

  always_comb begin
    w_nxt     = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_RST:      w_nxt = S_FETCH;
      S_FETCH:    w_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.opcode == OP_LW) || (bus.opcode == OP_SW):
            w_nxt = S_MEM_ADDR;
          (bus.opcode == OP_R) && (bus.funct == F_JR):
            w_nxt = S_JR;
          (bus.opcode == OP_R) && is_rfn(bus.funct):
            w_nxt = S_R_EXEC;
          (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE):
            w_nxt = S_BRANCH;
          (bus.opcode == OP_ADDI) || (bus.opcode == OP_SLTI):
            w_nxt = S_I_EXEC;
          (bus.opcode == OP_J):
            w_nxt = S_JUMP;
          (bus.opcode == OP_JAL):
            w_nxt = S_JAL;
          default: begin
            w_nxt     = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:
        w_nxt = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: w_nxt = S_MEM_WB;
      S_R_EXEC:   w_nxt = S_R_WB;
      S_I_EXEC:   w_nxt = S_I_WB;
      default:    w_nxt = S_FETCH;
    endcase
  end

  // Controls are precomputed for the next state so they leave flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RST;
      r_ctl   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_ctl   <= dec_ctrl(w_nxt, bus.opcode);
      if (r_state == S_FETCH)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  alu_decoder u_alu_dec (
    .i_alu_op   (r_ctl.alu_op),
    .i_funct    (bus.funct),
    .o_alu_ctrl (w_alu)
  );

  assign bus.IorD          = r_ctl.iord;
  assign bus.mem_read      = r_ctl.mem_read;
  assign bus.mem_write     = r_ctl.mem_write;
  assign bus.ir_write      = r_ctl.ir_write;
  assign bus.reg_dst       = r_ctl.reg_dst;
  assign bus.mem_to_reg    = r_ctl.mem_to_reg;
  assign bus.reg_write     = r_ctl.reg_write;
  assign bus.alu_src_a     = r_ctl.alu_src_a;
  assign bus.alu_src_b     = r_ctl.alu_src_b;
  assign bus.alu_ctrl      = r_ctl.alu_en ? w_alu : 3'b000;
  assign bus.pc_src        = r_ctl.pc_src;
  assign bus.pc_write      = r_ctl.pc_write;
  assign bus.pc_write_cond = r_ctl.pc_write_cond;
  assign bus.pc_en         = r_ctl.pc_write |
                             (r_ctl.pc_write_cond &
                              (bus.zero ^ r_ctl.is_bne));
  assign bus.jmp           = r_ctl.jmp;
  assign bus.jr            = r_ctl.jr;
  assign bus.illegal_op    = w_illegal;
  assign bus.instr_count   = r_cnt;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instructions
// push per-cycle expected controls, a negedge monitor compares.
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_controller_if #(.CNT_W(32)) bus();

  mc_controller #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic       jmp;
    logic       jr;
    logic       illegal_op;
  } ov_t;

  typedef struct {
    ov_t         v;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  typedef enum int {
    T_ZERO, T_F, T_D, T_MA, T_MR, T_MWB, T_MW,
    T_RX, T_RWB, T_BR, T_IX, T_IWB, T_J, T_JAL, T_JR
  } ts_e;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   n_fetch = 0;

  function automatic ov_t ref_v(input ts_e s, input logic [2:0] alu,
                                input logic pe, input logic ill);
    ov_t v;
    v = '0;
    case (s)
      T_F: begin
        v.mem_read = 1; v.ir_write = 1; v.alu_src_b = 2'b01;
        v.alu_ctrl = 3'b010; v.pc_write = 1; v.pc_en = 1;
      end
      T_D: begin
        v.alu_src_b = 2'b11; v.alu_ctrl = 3'b010; v.illegal_op = ill;
      end
      T_MA: begin
        v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010;
      end
      T_MR:  begin v.iord = 1; v.mem_read = 1; end
      T_MWB: begin v.mem_to_reg = 2'b01; v.reg_write = 1; end
      T_MW:  begin v.iord = 1; v.mem_write = 1; end
      T_RX:  begin v.alu_src_a = 1; v.alu_ctrl = alu; end
      T_RWB: begin v.reg_dst = 2'b01; v.reg_write = 1; end
      T_BR: begin
        v.alu_src_a = 1; v.alu_ctrl = 3'b110; v.pc_src = 2'b10;
        v.pc_write_cond = 1; v.pc_en = pe;
      end
      T_IX: begin
        v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_ctrl = alu;
      end
      T_IWB: v.reg_write = 1;
      T_J: begin
        v.pc_src = 2'b01; v.pc_write = 1; v.pc_en = 1; v.jmp = 1;
      end
      T_JAL: begin
        v.pc_src = 2'b01; v.pc_write = 1; v.pc_en = 1; v.jmp = 1;
        v.reg_dst = 2'b10; v.mem_to_reg = 2'b10; v.reg_write = 1;
      end
      T_JR: begin
        v.pc_src = 2'b11; v.pc_write = 1; v.pc_en = 1; v.jr = 1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic push(input ts_e s, input logic [31:0] c,
                      input string nm, input logic [2:0] alu,
                      input logic pe, input logic ill);
    exp_t e;
    e.v   = ref_v(s, alu, pe, ill);
    e.cnt = c;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Called at posedge+1 of a FETCH cycle; returns at the next FETCH.
  task automatic run(input string nm, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input int len,
                     input ts_e s2, input ts_e s3, input ts_e s4,
                     input logic [2:0] alu, input logic pe,
                     input logic ill);
    push(T_F, n_fetch, nm, alu, pe, ill);
    push(T_D, n_fetch + 1, nm, alu, pe, ill);
    if (len > 2) push(s2, n_fetch + 1, nm, alu, pe, ill);
    if (len > 3) push(s3, n_fetch + 1, nm, alu, pe, ill);
    if (len > 4) push(s4, n_fetch + 1, nm, alu, pe, ill);
    bus.opcode = 6'h3F;
    bus.funct  = 6'h3F;
    bus.zero   = z;
    @(posedge clk); #1;
    bus.opcode = op;
    bus.funct  = fn;
    repeat (len - 1) @(posedge clk);
    #1;
    n_fetch++;
  endtask

  function automatic ov_t sample();
    ov_t v;
    v.iord          = bus.IorD;
    v.mem_read      = bus.mem_read;
    v.mem_write     = bus.mem_write;
    v.ir_write      = bus.ir_write;
    v.reg_dst       = bus.reg_dst;
    v.mem_to_reg    = bus.mem_to_reg;
    v.reg_write     = bus.reg_write;
    v.alu_src_a     = bus.alu_src_a;
    v.alu_src_b     = bus.alu_src_b;
    v.alu_ctrl      = bus.alu_ctrl;
    v.pc_src        = bus.pc_src;
    v.pc_write      = bus.pc_write;
    v.pc_write_cond = bus.pc_write_cond;
    v.pc_en         = bus.pc_en;
    v.jmp           = bus.jmp;
    v.jr            = bus.jr;
    v.illegal_op    = bus.illegal_op;
    return v;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ov_t  g;
      e = sb.pop_front();
      g = sample();
      checks++;
      if (g !== e.v || bus.instr_count !== e.cnt) begin
        errs++;
        $display("FAIL %s t=%0t: got ctl=%h cnt=%0d want ctl=%h cnt=%0d",
                 e.nm, $time, g, bus.instr_count, e.v, e.cnt);
      end
    end
  end

  logic [5:0] rf[4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] ra[4] = '{3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    rst = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    #1;
    push(T_ZERO, 0, "reset", 3'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    push(T_ZERO, 0, "rst_state", 3'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    run("add", 6'h00, 6'h20, 1'b0, 4, T_RX, T_RWB, T_ZERO,
        3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run($sformatf("rtype_%h", rf[i]), 6'h00, rf[i], 1'b1, 4,
          T_RX, T_RWB, T_ZERO, ra[i], 1'b0, 1'b0);
    run("lw", 6'h23, 6'h11, 1'b0, 5, T_MA, T_MR, T_MWB,
        3'b0, 1'b0, 1'b0);
    run("sw", 6'h2B, 6'h20, 1'b0, 4, T_MA, T_MW, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 3, T_BR, T_ZERO, T_ZERO,
        3'b0, 1'b1, 1'b0);
    run("beq_z0", 6'h04, 6'h00, 1'b0, 3, T_BR, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 3, T_BR, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 3, T_BR, T_ZERO, T_ZERO,
        3'b0, 1'b1, 1'b0);
    run("addi", 6'h08, 6'h2A, 1'b0, 4, T_IX, T_IWB, T_ZERO,
        3'b010, 1'b0, 1'b0);
    run("slti", 6'h0A, 6'h20, 1'b0, 4, T_IX, T_IWB, T_ZERO,
        3'b111, 1'b0, 1'b0);
    run("j", 6'h02, 6'h00, 1'b0, 3, T_J, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("jal", 6'h03, 6'h00, 1'b0, 3, T_JAL, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("jr", 6'h00, 6'h08, 1'b0, 3, T_JR, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b0);
    run("illegal_3f", 6'h3F, 6'h20, 1'b0, 2, T_ZERO, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b1);
    run("illegal_fn", 6'h00, 6'h3F, 1'b0, 2, T_ZERO, T_ZERO, T_ZERO,
        3'b0, 1'b0, 1'b1);
    run("after_ill", 6'h00, 6'h25, 1'b0, 4, T_RX, T_RWB, T_ZERO,
        3'b001, 1'b0, 1'b0);

    // lw interrupted by reset while in MEM_READ
    push(T_F, n_fetch, "lw_cut", 3'b0, 1'b0, 1'b0);
    push(T_D, n_fetch + 1, "lw_cut", 3'b0, 1'b0, 1'b0);
    push(T_MA, n_fetch + 1, "lw_cut", 3'b0, 1'b0, 1'b0);
    bus.opcode = 6'h3F;
    @(posedge clk); #1;
    bus.opcode = 6'h23;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push(T_ZERO, 0, "mid_rst", 3'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    push(T_ZERO, 0, "rst_rel", 3'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_fetch = 0;
    run("add_post_rst", 6'h00, 6'h20, 1'b0, 4, T_RX, T_RWB, T_ZERO,
        3'b010, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
